// File: rtl/rv_mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// rv_mc_ctrl_if : sequencer <-> imem / dmem / FP multiplier / register files
// Revision      : 1.0
// ============================================================================
interface rv_mc_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        fmul_start;
  logic        fmul_done;
  logic        xreg_we;
  logic        freg_we;
  logic [1:0]  wb_sel;
  logic        halted;
  logic        trap;
  logic [1:0]  trap_cause;

  modport master (
    output imem_addr, instr, pc, dmem_req, dmem_we, fmul_start,
           xreg_we, freg_we, wb_sel, halted, trap, trap_cause,
    input  imem_rdata, dmem_ready, fmul_done
  );

  modport slave (
    input  imem_addr, instr, pc, dmem_req, dmem_we, fmul_start,
           xreg_we, freg_we, wb_sel, halted, trap, trap_cause,
    output imem_rdata, dmem_ready, fmul_done
  );
endinterface
`default_nettype wire

// File: rtl/rv_mc_ctrl.sv
`default_nettype none
// ============================================================================
// rv_mc_ctrl : multi-cycle fetch/decode sequencer for the mini RISC-V FP core
// Revision   : 1.0
// ============================================================================
module rv_mc_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64,
  parameter int          TIMEOUT    = 16
) (
  input  wire logic    clk,
  input  wire logic    rst,
  rv_mc_ctrl_if.master bus
);
  localparam int              CNT_W        = $clog2(TIMEOUT + 1);
  localparam logic [31:0]     c_imem_limit = 32'(IMEM_WORDS * 4);
  localparam logic [CNT_W-1:0] c_timeout   = CNT_W'(TIMEOUT);
  localparam logic [31:0]     c_nop        = 32'h0000_0013;
  localparam logic [31:0]     c_ebreak     = 32'h0010_0073;
  localparam logic [1:0]      c_cause_ill  = 2'd0;
  localparam logic [1:0]      c_cause_pc   = 2'd1;
  localparam logic [1:0]      c_cause_dmem = 2'd2;
  localparam logic [1:0]      c_cause_fmul = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_FWAIT, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d, instr_q, instr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic              fmul_start_q, fmul_start_d;
  logic              xreg_we_q, xreg_we_d, freg_we_q, freg_we_d;
  logic [1:0]        wb_sel_q, wb_sel_d;
  logic              halted_q, halted_d, trap_q, trap_d;
  logic [1:0]        trap_cause_q, trap_cause_d;
  logic              enter_wb, trap_req;
  logic [1:0]        trap_code;

  logic [6:0] opcode;
  logic       is_lui, is_opimm, is_flw, is_fsw, is_fmul, is_ebreak;

  assign opcode    = instr_q[6:0];
  assign is_ebreak = (instr_q == c_ebreak);
  assign is_lui    = (opcode == 7'b0110111);
  assign is_opimm  = (opcode == 7'b0010011);
  assign is_flw    = (opcode == 7'b0000111) && (instr_q[14:12] == 3'b010);
  assign is_fsw    = (opcode == 7'b0100111) && (instr_q[14:12] == 3'b010);
  assign is_fmul   = (opcode == 7'b1010011) && (instr_q[31:25] == 7'b0001000);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    cnt_d        = cnt_q;
    dmem_req_d   = 1'b0;
    dmem_we_d    = 1'b0;
    fmul_start_d = 1'b0;
    xreg_we_d    = 1'b0;
    freg_we_d    = 1'b0;
    wb_sel_d     = 2'd0;
    halted_d     = halted_q;
    trap_d       = trap_q;
    trap_cause_d = trap_cause_q;
    enter_wb     = 1'b0;
    trap_req     = 1'b0;
    trap_code    = c_cause_ill;

    // Strobes are registered: each is raised on the transition into the state that owns it.
    case (state_q)
      S_FETCH: begin
        if (pc_q >= c_imem_limit) begin
          trap_req  = 1'b1;
          trap_code = c_cause_pc;
        end else begin
          instr_d = bus.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_ebreak) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (is_lui || is_opimm) begin
          enter_wb = 1'b1;
        end else if (is_flw || is_fsw) begin
          state_d    = S_MEM;
          dmem_req_d = 1'b1;
          dmem_we_d  = is_fsw;
          cnt_d      = '0;
        end else if (is_fmul) begin
          state_d      = S_EXEC;
          fmul_start_d = 1'b1;
        end else begin
          trap_req  = 1'b1;
          trap_code = c_cause_ill;
        end
      end
      S_EXEC: begin
        state_d = S_FWAIT;
        cnt_d   = '0;
      end
      S_FWAIT: begin
        if (bus.fmul_done) begin
          enter_wb = 1'b1;
        end else if (cnt_inc == c_timeout) begin
          trap_req  = 1'b1;
          trap_code = c_cause_fmul;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_MEM: begin
        // Ready is checked before the timeout so a last-cycle response still completes.
        if (bus.dmem_ready) begin
          if (is_fsw) begin
            pc_d    = pc_q + 32'd4;
            state_d = S_FETCH;
          end else begin
            enter_wb = 1'b1;
          end
        end else if (cnt_inc == c_timeout) begin
          trap_req  = 1'b1;
          trap_code = c_cause_dmem;
        end else begin
          cnt_d      = cnt_inc;
          dmem_req_d = 1'b1;
          dmem_we_d  = is_fsw;
        end
      end
      S_WB: begin
        pc_d    = pc_q + 32'd4;
        state_d = S_FETCH;
      end
      default: ;
    endcase

    if (enter_wb) begin
      state_d   = S_WB;
      xreg_we_d = is_lui || is_opimm;
      freg_we_d = is_flw || is_fmul;
      wb_sel_d  = is_fmul ? 2'd3 : is_flw ? 2'd2 : is_opimm ? 2'd1 : 2'd0;
    end

    if (trap_req) begin
      state_d      = S_TRAP;
      trap_d       = 1'b1;
      trap_cause_d = trap_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= c_nop;
      cnt_q        <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      fmul_start_q <= 1'b0;
      xreg_we_q    <= 1'b0;
      freg_we_q    <= 1'b0;
      wb_sel_q     <= 2'd0;
      halted_q     <= 1'b0;
      trap_q       <= 1'b0;
      trap_cause_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      cnt_q        <= cnt_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      fmul_start_q <= fmul_start_d;
      xreg_we_q    <= xreg_we_d;
      freg_we_q    <= freg_we_d;
      wb_sel_q     <= wb_sel_d;
      halted_q     <= halted_d;
      trap_q       <= trap_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.pc         = pc_q;
  assign bus.instr      = instr_q;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.fmul_start = fmul_start_q;
  assign bus.xreg_we    = xreg_we_q;
  assign bus.freg_we    = freg_we_q;
  assign bus.wb_sel     = wb_sel_q;
  assign bus.halted     = halted_q;
  assign bus.trap       = trap_q;
  assign bus.trap_cause = trap_cause_q;
endmodule
`default_nettype wire

// File: tb/tb_rv_mc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rv_mc_ctrl : vector table, directed corner cases and random programs
// Revision      : 1.0
// ============================================================================
module tb_rv_mc_ctrl;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBRK   = 32'h0010_0073;
  localparam logic [31:0] LUI1   = 32'h0000_10B7;
  localparam logic [31:0] FLW1   = 32'h0000_A087;
  localparam logic [31:0] FLW2   = 32'h0040_A107;
  localparam logic [31:0] FMUL   = 32'h1020_81D3;
  localparam logic [31:0] FSW3   = 32'h0030_A427;
  localparam int          NEVER  = 255;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  rv_mc_ctrl_if bus_a ();
  rv_mc_ctrl_if bus_b ();

  logic [31:0] imem [64];
  logic        ready_a = 1'b0;
  logic        done_a  = 1'b0;

  assign bus_a.imem_rdata = (bus_a.imem_addr < 32'd256) ? imem[bus_a.imem_addr[7:2]] : 32'h0;
  assign bus_a.dmem_ready = ready_a;
  assign bus_a.fmul_done  = done_a;
  assign bus_b.imem_rdata = NOP;
  assign bus_b.dmem_ready = 1'b0;
  assign bus_b.fmul_done  = 1'b0;

  rv_mc_ctrl dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  rv_mc_ctrl #(.IMEM_WORDS(4)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  // Handshake responders: each access/multiply consumes the next delay from its queue.
  int mem_q[$];
  int mul_q[$];
  int mem_cnt, mem_del, mul_cnt, mul_lat;
  bit mem_busy, mul_busy;

  always @(negedge clk) begin
    if (rst_a) begin
      mem_busy = 0; mul_busy = 0; ready_a = 1'b0; done_a = 1'b0;
    end else begin
      if (bus_a.dmem_req) begin
        if (!mem_busy) begin
          mem_busy = 1; mem_cnt = 0;
          mem_del  = (mem_q.size() > 0) ? mem_q.pop_front() : 0;
        end else begin
          mem_cnt++;
        end
        ready_a = (mem_cnt == mem_del);
      end else begin
        mem_busy = 0; ready_a = 1'b0;
      end
      if (bus_a.fmul_start) begin
        mul_busy = 1; mul_cnt = 0; done_a = 1'b0;
        mul_lat  = (mul_q.size() > 0) ? mul_q.pop_front() : 1;
      end else if (mul_busy) begin
        mul_cnt++;
        done_a = (mul_cnt == mul_lat);
        if (done_a) mul_busy = 0;
      end else begin
        done_a = 1'b0;
      end
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    mem_q.delete();
    mul_q.delete();
    for (int k = 0; k < 64; k++) imem[k] = NOP;
    @(negedge clk);
    @(negedge clk);
  endtask

  int r_stop, r_xc, r_fc, r_wc, r_rc, r_last_req, r_first_wb;

  // Releases reset and observes until HALT/TRAP; r_stop = -1 when the budget runs out.
  task automatic run_a(input int budget);
    bit prev_we;
    rst_a = 1'b0;
    r_stop = -1; r_xc = 0; r_fc = 0; r_wc = 0; r_rc = 0;
    r_last_req = -1; r_first_wb = -1; prev_we = 1'b0;
    for (int cyc = 2; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (bus_a.xreg_we) r_xc++;
      if (bus_a.freg_we) r_fc++;
      if ((bus_a.xreg_we || bus_a.freg_we) && r_first_wb < 0) r_first_wb = cyc;
      if (bus_a.dmem_we && !prev_we) r_wc++;
      prev_we = bus_a.dmem_we;
      if (bus_a.dmem_req) begin r_rc++; r_last_req = cyc; end
      if (bus_a.halted || bus_a.trap) begin r_stop = cyc; break; end
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    int          mdel;
    int          mlat;
    int          stop;
    bit          trapped;
    logic [1:0]  cause;
    logic [31:0] pc;
    int          xc, fc, wc, rc;
  } vec_t;

  vec_t vecs[14];

  // Random programs: timing and strobe totals come from per-instruction cycle costs.
  task automatic rand_test(input int iters);
    int n, kind, d, exp_cyc, ex, ef, ew, er;
    bit ill;
    logic [31:0] r;
    for (int it = 0; it < iters; it++) begin
      reset_a();
      n = $urandom_range(1, 6);
      ill = ($urandom_range(0, 3) == 0);
      exp_cyc = 0; ex = 0; ef = 0; ew = 0; er = 0;
      for (int k = 0; k < n; k++) begin
        kind = $urandom_range(0, 4);
        r = $urandom();
        case (kind)
          0: begin imem[k] = {r[31:7], 7'b0110111}; exp_cyc += 3; ex++; end
          1: begin imem[k] = {r[31:7], 7'b0010011}; exp_cyc += 3; ex++; end
          2: begin
            d = $urandom_range(0, 6); mem_q.push_back(d);
            imem[k] = {r[31:15], 3'b010, r[11:7], 7'b0000111};
            exp_cyc += 4 + d; ef++; er += d + 1;
          end
          3: begin
            d = $urandom_range(0, 6); mem_q.push_back(d);
            imem[k] = {r[31:15], 3'b010, r[11:7], 7'b0100111};
            exp_cyc += 3 + d; ew++; er += d + 1;
          end
          default: begin
            d = $urandom_range(1, 6); mul_q.push_back(d);
            imem[k] = {7'b0001000, r[24:15], r[14:12], r[11:7], 7'b1010011};
            exp_cyc += 4 + d; ef++;
          end
        endcase
      end
      r = $urandom();
      imem[n] = ill ? {r[31:7], 7'b1111111} : EBRK;
      run_a(exp_cyc + 20);
      check("rand_stop_cycle", r_stop, exp_cyc + 3);
      check("rand_pc", bus_a.pc, 32'(4 * n));
      check("rand_trap", {31'd0, bus_a.trap}, {31'd0, ill});
      check("rand_halted", {31'd0, bus_a.halted}, {31'd0, !ill});
      check("rand_xreg_we", r_xc, ex);
      check("rand_freg_we", r_fc, ef);
      check("rand_dmem_we", r_wc, ew);
      check("rand_dmem_req", r_rc, er);
    end
  endtask

  initial begin
    int bx, bstop;

    //          ins          mdel   mlat   stop trp cause  pc     xc fc wc rc
    vecs[0]  = '{LUI1,         0,     0,     6, 0, 2'd0, 32'd4, 1, 0, 0, 0};
    vecs[1]  = '{NOP,          0,     0,     6, 0, 2'd0, 32'd4, 1, 0, 0, 0};
    vecs[2]  = '{FLW1,         0,     0,     7, 0, 2'd0, 32'd4, 0, 1, 0, 1};
    vecs[3]  = '{FLW1,         5,     0,    12, 0, 2'd0, 32'd4, 0, 1, 0, 6};
    vecs[4]  = '{FLW1,        15,     0,    22, 0, 2'd0, 32'd4, 0, 1, 0, 16};
    vecs[5]  = '{FSW3,         0,     0,     6, 0, 2'd0, 32'd4, 0, 0, 1, 1};
    vecs[6]  = '{FMUL,         0,     3,    10, 0, 2'd0, 32'd4, 0, 1, 0, 0};
    vecs[7]  = '{FMUL,         0,    16,    23, 0, 2'd0, 32'd4, 0, 1, 0, 0};
    vecs[8]  = '{FMUL,         0, NEVER,    20, 1, 2'd3, 32'd0, 0, 0, 0, 0};
    vecs[9]  = '{FSW3,     NEVER,     0,    19, 1, 2'd2, 32'd0, 0, 0, 1, 16};
    vecs[10] = '{32'hFFFF_FFFF, 0,    0,     3, 1, 2'd0, 32'd0, 0, 0, 0, 0};
    vecs[11] = '{EBRK,         0,     0,     3, 0, 2'd0, 32'd0, 0, 0, 0, 0};
    vecs[12] = '{32'h0000_B087, 0,    0,     3, 1, 2'd0, 32'd0, 0, 0, 0, 0};
    vecs[13] = '{32'h0020_81D3, 0,    0,     3, 1, 2'd0, 32'd0, 0, 0, 0, 0};

    reset_a();
    check("rst_pc", bus_a.pc, 32'h0);
    check("rst_imem_addr", bus_a.imem_addr, 32'h0);
    check("rst_instr", bus_a.instr, NOP);
    check("rst_strobes", {26'd0, bus_a.dmem_req, bus_a.dmem_we, bus_a.fmul_start,
                          bus_a.xreg_we, bus_a.freg_we, bus_a.halted}, 32'd0);
    check("rst_trap", {27'd0, bus_a.trap, bus_a.trap_cause, bus_a.wb_sel}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      reset_a();
      imem[0] = vecs[i].ins;
      imem[1] = EBRK;
      mem_q.push_back(vecs[i].mdel);
      mul_q.push_back(vecs[i].mlat);
      run_a(60);
      check($sformatf("v%0d_stop_cycle", i), r_stop, vecs[i].stop);
      check($sformatf("v%0d_trap", i), {31'd0, bus_a.trap}, {31'd0, vecs[i].trapped});
      check($sformatf("v%0d_halted", i), {31'd0, bus_a.halted}, {31'd0, !vecs[i].trapped});
      check($sformatf("v%0d_cause", i), {30'd0, bus_a.trap_cause}, {30'd0, vecs[i].cause});
      check($sformatf("v%0d_pc", i), bus_a.pc, vecs[i].pc);
      check($sformatf("v%0d_xreg_we", i), r_xc, vecs[i].xc);
      check($sformatf("v%0d_freg_we", i), r_fc, vecs[i].fc);
      check($sformatf("v%0d_dmem_we", i), r_wc, vecs[i].wc);
      check($sformatf("v%0d_dmem_req", i), r_rc, vecs[i].rc);
      check($sformatf("v%0d_wb_sel_idle", i), {30'd0, bus_a.wb_sel}, 32'd0);
    end

    // Full test-plan program, zero-wait memory, 3-cycle multiply.
    reset_a();
    imem[0] = LUI1; imem[1] = FLW1; imem[2] = FLW2;
    imem[3] = FMUL; imem[4] = FSW3; imem[5] = EBRK;
    mem_q.push_back(0); mem_q.push_back(0); mem_q.push_back(0);
    mul_q.push_back(3);
    run_a(80);
    check("prog_halt_cycle", r_stop, 24);
    check("prog_pc", bus_a.pc, 32'h14);
    check("prog_halted", {31'd0, bus_a.halted}, 32'd1);
    check("prog_dmem_we", r_wc, 1);
    check("prog_freg_we", r_fc, 3);
    check("prog_xreg_we", r_xc, 1);

    // FLW with 5-cycle ready delay: write-back directly follows the last request cycle.
    reset_a();
    imem[0] = FLW1; imem[1] = EBRK;
    mem_q.push_back(5);
    run_a(60);
    check("flw_wait_req_cycles", r_rc, 6);
    check("flw_wait_wb_follows", r_first_wb, r_last_req + 1);
    check("flw_wait_pc", bus_a.pc, 32'd4);

    // Illegal word at pc 0x8.
    reset_a();
    imem[2] = 32'hFFFF_FFFF;
    run_a(40);
    check("ill_trap_cycle", r_stop, 9);
    check("ill_cause", {30'd0, bus_a.trap_cause}, 32'd0);
    check("ill_pc", bus_a.pc, 32'h8);
    check("ill_xreg_we", r_xc, 2);

    // Asynchronous reset while a load waits in MEM.
    reset_a();
    imem[0] = FLW1;
    mem_q.push_back(NEVER);
    rst_a = 1'b0;
    bx = 0;
    while (!bus_a.dmem_req && bx < 10) begin @(negedge clk); bx++; end
    check("arst_req_seen", {31'd0, bus_a.dmem_req}, 32'd1);
    #2 rst_a = 1'b1;
    #1;
    check("arst_req_drop", {31'd0, bus_a.dmem_req}, 32'd0);
    check("arst_pc", bus_a.pc, 32'h0);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    check("arst_first_fetch", bus_a.instr, FLW1);
    check("arst_pc_hold", bus_a.pc, 32'h0);

    // IMEM_WORDS = 4: four NOPs then a fetch-range trap.
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    bx = 0; bstop = -1;
    for (int cyc = 2; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (bus_b.xreg_we) bx++;
      if (bus_b.trap || bus_b.halted) begin bstop = cyc; break; end
    end
    check("range_stop_cycle", bstop, 14);
    check("range_xreg_we", bx, 4);
    check("range_trap", {31'd0, bus_b.trap}, 32'd1);
    check("range_cause", {30'd0, bus_b.trap_cause}, 32'd1);
    check("range_pc", bus_b.pc, 32'h10);

    rand_test(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rv_mc_ctrl.md
Name: rv_mc_ctrl

Overview:
- Multi-cycle sequencer for the mini RISC-V FP core.
- Owns the PC and the instruction register, and fetches from the combinational instruction memory.
- Decodes the supported subset (LUI, OP-IMM, FLW, FSW, FMUL.S, EBREAK).
- Drives strobes and handshakes to the data memory, the multi-cycle FP multiplier and the register files.
- Stops on EBREAK, illegal opcode, out-of-range fetch or handshake timeout.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 64, instruction memory depth; fetch from byte address >= IMEM_WORDS*4 traps.
- TIMEOUT, 16, maximum wait cycles for dmem_ready or fmul_done before trapping.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  fetch address (= pc).
- imem_rdata  in  32  instruction word, combinational from imem_addr.
- instr  out  32  instruction register.
- pc  out  32  current PC.
- dmem_req  out  1  data access request.
- dmem_we  out  1  store qualifier, valid with dmem_req.
- dmem_ready  in  1  data access complete.
- fmul_start  out  1  one-cycle start pulse to the FP multiplier.
- fmul_done  in  1  multiplier result valid.
- xreg_we  out  1  integer register write strobe.
- freg_we  out  1  FP register write strobe.
- wb_sel  out  2  write-back source: 0 = IMM(U), 1 = ALU, 2 = DMEM, 3 = FMUL.
- halted  out  1  EBREAK reached.
- trap  out  1  fault stop.
- trap_cause  out  2  fault code: 0 = illegal, 1 = fetch range, 2 = dmem timeout, 3 = fmul timeout.

Behaviour:
- Reset (async, any state): pc = RESET_PC, instr = 32'h0000_0013, state = FETCH, wait counter = 0. All strobes, halted, trap and trap_cause are 0. Reset mid-handshake drops dmem_req and fmul_start immediately.
- States: FETCH, DECODE, EXEC, FWAIT, MEM, WB, HALT, TRAP.
- FETCH (1 cycle):
  - If pc >= IMEM_WORDS*4 -> TRAP, cause 1.
  - Otherwise instr <= imem_rdata -> DECODE.
- DECODE (1 cycle), classified on instr:
  - Exactly 32'h0010_0073 -> HALT.
  - Opcode 0110111 (LUI) or 0010011 (OP-IMM) -> WB.
  - Opcode 0000111 with funct3 = 010 (FLW), or opcode 0100111 with funct3 = 010 (FSW) -> MEM.
  - Opcode 1010011 with funct7 = 0001000 (FMUL.S) -> EXEC.
  - Anything else -> TRAP, cause 0.
- EXEC (1 cycle): fmul_start = 1 -> FWAIT. fmul_done is ignored in this cycle.
- FWAIT:
  - fmul_done = 1 -> WB.
  - Otherwise the counter increments; when the counter reaches TIMEOUT -> TRAP, cause 3.
- MEM:
  - dmem_req = 1 for the whole state; dmem_we = 1 for FSW only.
  - On dmem_ready = 1 (including the first cycle): FLW -> WB; FSW -> pc <= pc+4, go to FETCH.
  - No ready for TIMEOUT cycles -> TRAP, cause 2.
- Wait counter clears on entry to FWAIT and to MEM.
- WB (1 cycle): exactly one write strobe, then pc <= pc+4 -> FETCH.
  - LUI: xreg_we, wb_sel 0.
  - OP-IMM: xreg_we, wb_sel 1.
  - FLW: freg_we, wb_sel 2.
  - FMUL.S: freg_we, wb_sel 3.
- wb_sel is 0 outside WB.
- HALT and TRAP are absorbing until reset.
  - halted, or trap with trap_cause, is registered and high from the first cycle in the state.
  - pc holds the address of the offending or EBREAK instruction.
  - No strobes are issued.
- PC arithmetic is 32-bit modulo. pc is never incremented in HALT or TRAP.
- Simultaneous dmem_ready and timeout expiry in the same cycle: ready wins.
- Cycle costs with zero-wait handshakes:
  - LUI / OP-IMM: 3.
  - FLW: 4.
  - FSW: 3.
  - FMUL.S: 4 + fmul latency.
  - EBREAK: 2 cycles, then HALT.

Test Plan:
- Program LUI x1,0x1; FLW f1,0(x1); FLW f2,4(x1); FMUL.S f3,f1,f2; FSW f3,8(x1); EBREAK, with dmem_ready tied 1 and fmul_done 3 cycles after start -> halted rises on cycle 24 after reset release; pc = 0x14; exactly one dmem_we pulse; freg_we pulses = 3; xreg_we pulses = 1.
- FLW with dmem_ready delayed 5 cycles -> dmem_req held 6 cycles; freg_we on the following cycle; pc advances by 4.
- FMUL.S with fmul_done never asserted, TIMEOUT = 16 -> trap = 1, trap_cause = 3, pc unchanged, no freg_we.
- instr 32'hFFFF_FFFF at pc 0x8 -> trap, cause 0, two cycles after entering FETCH; pc = 0x8.
- IMEM_WORDS = 4 with NOPs only -> four xreg_we pulses, then trap cause 1 with pc = 0x10.
- Assert rst during MEM with dmem_req high -> dmem_req low in the same cycle; after release, pc = RESET_PC and first state is FETCH.
